// File: rtl/stream_config_decoder.sv
// stream_config_decoder
//
// Slave end of the config write bus. Register writes at BASE_ADDR update a
// staged tuple {in_select, out_select, data_type}. A COMMIT write pushes the
// staged tuple into a small FIFO. The FIFO head is presented on three
// independent ready/valid channels. The head is popped once every channel
// has taken it.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 IN_SEL, 0x08 OUT_SEL, 0x10 DATA_TYPE, 0x18 COMMIT, 0x20 CLEAR
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   conf_addr/data/valid      config write bus, no backpressure
//   stream_conf_in_select_*   in_select channel (data, valid out; ready in)
//   stream_conf_out_select_*  out_select channel
//   stream_conf_data_type_*   data_type channel
//   pending                   number of tuples in the FIFO
//   overflow                  sticky, a commit was dropped
//   range_err                 sticky, a select write was >= NUM_SELECT
//   drop_count                dropped commits, saturating
module stream_config_decoder #(
  parameter int unsigned NUM_SELECT  = 4,  // must be >= 2
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned QUEUE_DEPTH = 4,  // power of two, >= 2
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned DATA_BITS   = 32,
  parameter int unsigned TYPE_BITS   = 4,
  localparam int unsigned SEL_W      = $clog2(NUM_SELECT),
  localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [ADDR_BITS-1:0] conf_addr,
  input  logic [DATA_BITS-1:0] conf_data,
  input  logic                 conf_valid,

  output logic [SEL_W-1:0]     stream_conf_in_select_data,
  output logic                 stream_conf_in_select_valid,
  input  logic                 stream_conf_in_select_ready,

  output logic [SEL_W-1:0]     stream_conf_out_select_data,
  output logic                 stream_conf_out_select_valid,
  input  logic                 stream_conf_out_select_ready,

  output logic [TYPE_BITS-1:0] stream_conf_data_type_data,
  output logic                 stream_conf_data_type_valid,
  input  logic                 stream_conf_data_type_ready,

  output logic [CNT_W-1:0]     pending,
  output logic                 overflow,
  output logic                 range_err,
  output logic [31:0]          drop_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

  localparam logic [ADDR_BITS-1:0] OFF_IN_SEL    = ADDR_BITS'(32'h00);
  localparam logic [ADDR_BITS-1:0] OFF_OUT_SEL   = ADDR_BITS'(32'h08);
  localparam logic [ADDR_BITS-1:0] OFF_DATA_TYPE = ADDR_BITS'(32'h10);
  localparam logic [ADDR_BITS-1:0] OFF_COMMIT    = ADDR_BITS'(32'h18);
  localparam logic [ADDR_BITS-1:0] OFF_CLEAR     = ADDR_BITS'(32'h20);

  // Staged fields
  logic [SEL_W-1:0]     in_sel_q, in_sel_d;
  logic [SEL_W-1:0]     out_sel_q, out_sel_d;
  logic [TYPE_BITS-1:0] dtype_q, dtype_d;

  // Status
  logic                 overflow_q, overflow_d;
  logic                 range_err_q, range_err_d;
  logic [31:0]          drop_count_q, drop_count_d;

  // FIFO storage and pointers
  logic [SEL_W-1:0]     in_mem_q    [QUEUE_DEPTH];
  logic [SEL_W-1:0]     out_mem_q   [QUEUE_DEPTH];
  logic [TYPE_BITS-1:0] dtype_mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Per-channel "head already accepted" bits: [0] in, [1] out, [2] type
  logic [2:0]           taken_q, taken_d;

  // Decode
  logic [ADDR_BITS-1:0] offset;
  logic                 wr_in_sel, wr_out_sel, wr_dtype, wr_commit, wr_clear;
  logic                 sel_in_range;

  // FIFO control
  logic                 empty, full, push, pop, drop;
  logic [2:0]           valid_vec, ready_vec, hs_vec;

  // Wrapping subtraction: addresses below BASE_ADDR land far above 0x20.
  assign offset       = conf_addr - ADDR_BITS'(BASE_ADDR);
  assign wr_in_sel    = conf_valid && (offset == OFF_IN_SEL);
  assign wr_out_sel   = conf_valid && (offset == OFF_OUT_SEL);
  assign wr_dtype     = conf_valid && (offset == OFF_DATA_TYPE);
  assign wr_commit    = conf_valid && (offset == OFF_COMMIT);
  assign wr_clear     = conf_valid && (offset == OFF_CLEAR);
  assign sel_in_range = conf_data < DATA_BITS'(NUM_SELECT);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  // valid is purely registered state; it never looks at ready.
  assign valid_vec = {3{!empty}} & ~taken_q;
  assign ready_vec = {stream_conf_data_type_ready,
                      stream_conf_out_select_ready,
                      stream_conf_in_select_ready};
  assign hs_vec    = valid_vec & ready_vec;
  // Pop once every channel has taken the head, including handshakes this cycle.
  assign pop       = !empty && (&(taken_q | hs_vec));
  // A full FIFO still accepts a commit when the head leaves on the same edge.
  assign push      = wr_commit && (!full || pop);
  assign drop      = wr_commit && !push;

  always_comb begin
    in_sel_d     = in_sel_q;
    out_sel_d    = out_sel_q;
    dtype_d      = dtype_q;
    overflow_d   = overflow_q;
    range_err_d  = range_err_q;
    drop_count_d = drop_count_q;

    if (wr_in_sel) begin
      if (sel_in_range) in_sel_d = conf_data[SEL_W-1:0];
      else              range_err_d = 1'b1;
    end
    if (wr_out_sel) begin
      if (sel_in_range) out_sel_d = conf_data[SEL_W-1:0];
      else              range_err_d = 1'b1;
    end
    if (wr_dtype) begin
      dtype_d = conf_data[TYPE_BITS-1:0];
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + 32'd1;
    end
    if (wr_clear) begin
      overflow_d   = 1'b0;
      range_err_d  = 1'b0;
      drop_count_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    taken_d  = taken_q | hs_vec;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      taken_d  = '0;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sel_q     <= '0;
      out_sel_q    <= '0;
      dtype_q      <= '0;
      overflow_q   <= 1'b0;
      range_err_q  <= 1'b0;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      taken_q      <= '0;
    end else begin
      in_sel_q     <= in_sel_d;
      out_sel_q    <= out_sel_d;
      dtype_q      <= dtype_d;
      overflow_q   <= overflow_d;
      range_err_q  <= range_err_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      taken_q      <= taken_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        in_mem_q[i]    <= '0;
        out_mem_q[i]   <= '0;
        dtype_mem_q[i] <= '0;
      end
    end else if (push) begin
      in_mem_q[wr_ptr_q]    <= in_sel_q;
      out_mem_q[wr_ptr_q]   <= out_sel_q;
      dtype_mem_q[wr_ptr_q] <= dtype_q;
    end
  end

  assign stream_conf_in_select_data   = in_mem_q[rd_ptr_q];
  assign stream_conf_out_select_data  = out_mem_q[rd_ptr_q];
  assign stream_conf_data_type_data   = dtype_mem_q[rd_ptr_q];
  assign stream_conf_in_select_valid  = valid_vec[0];
  assign stream_conf_out_select_valid = valid_vec[1];
  assign stream_conf_data_type_valid  = valid_vec[2];

  assign pending    = count_q;
  assign overflow   = overflow_q;
  assign range_err  = range_err_q;
  assign drop_count = drop_count_q;

endmodule
